// File: rtl/pirdsp_pkg.sv
// Shared types and product bit-field constants for the PIRDSP 9x9 MAC datapath.
package pirdsp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int unsigned LANE0_LSB   = 0;
  localparam int unsigned LANE1_LSB   = 10;
  localparam int unsigned LANE_PROD_W = 8;
  localparam int unsigned FULL_PROD_W = 18;

endpackage

// File: rtl/pirdsp_sat_add.sv
// WIDTH-bit adder with signed/unsigned overflow detection and optional clamping.
module pirdsp_sat_add #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] sum_c,
  output logic             overflow_c
);

  logic [WIDTH:0] raw;
  logic           ovf;

  assign raw = {1'b0, a} + {1'b0, b};

  // Signed overflow: like-signed operands producing an opposite-signed result.
  always_comb begin
    sum_c = raw[WIDTH-1:0];
    ovf   = 1'b0;
    if (is_signed) begin
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      if (ovf && SATURATE) begin
        sum_c = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      ovf = raw[WIDTH];
      if (ovf && SATURATE) begin
        sum_c = '1;
      end
    end
    overflow_c = ovf;
  end

endmodule

// File: rtl/pirdsp_mac_accumulator_9x9.sv
// Accumulates 9x9 PIRDSP products framed by first/last, as one full-width sum or two lane sums.
module pirdsp_mac_accumulator_9x9
  import pirdsp_pkg::*;
#(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned LANE_ACC_W = 16,
  parameter int unsigned CNT_W      = 8,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [FULL_PROD_W-1:0] in_C,
  input  logic                   in_sign,
  input  logic                   in_half,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       out_acc0,
  output logic [LANE_ACC_W-1:0]  out_acc1,
  output logic                   out_half,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_overflow
);

  state_t                 state_q, state_d;
  logic                   half_q, sign_q, ovf_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ACC_W-1:0]       full_q;
  logic [LANE_ACC_W-1:0]  lane0_q, lane1_q;

  logic                   start_c, eff_half, eff_sign, ovf_d;
  logic [LANE_PROD_W-1:0] lane0_prod, lane1_prod;
  logic [ACC_W-1:0]       full_ext, full_base, full_sum, acc0_d;
  logic [LANE_ACC_W-1:0]  lane0_ext, lane1_ext, lane0_base, lane1_base;
  logic [LANE_ACC_W-1:0]  lane0_sum, lane1_sum, acc1_d;
  logic                   full_ovf, lane0_ovf, lane1_ovf;

  // A starting beat adds onto zero, so it simply loads the extended product.
  always_comb begin
    start_c    = in_valid && (in_first || (state_q == IDLE));
    eff_half   = start_c ? in_half : half_q;
    eff_sign   = start_c ? in_sign : sign_q;
    lane0_prod = in_C[LANE0_LSB +: LANE_PROD_W];
    lane1_prod = in_C[LANE1_LSB +: LANE_PROD_W];
    if (eff_sign) begin
      full_ext  = ACC_W'($signed(in_C));
      lane0_ext = LANE_ACC_W'($signed(lane0_prod));
      lane1_ext = LANE_ACC_W'($signed(lane1_prod));
    end else begin
      full_ext  = ACC_W'(in_C);
      lane0_ext = LANE_ACC_W'(lane0_prod);
      lane1_ext = LANE_ACC_W'(lane1_prod);
    end
    full_base  = start_c ? '0 : full_q;
    lane0_base = start_c ? '0 : lane0_q;
    lane1_base = start_c ? '0 : lane1_q;
  end

  pirdsp_sat_add #(.WIDTH(ACC_W), .SATURATE(SATURATE)) u_add_full (
    .a(full_base), .b(full_ext), .is_signed(eff_sign),
    .sum_c(full_sum), .overflow_c(full_ovf)
  );

  pirdsp_sat_add #(.WIDTH(LANE_ACC_W), .SATURATE(SATURATE)) u_add_lane0 (
    .a(lane0_base), .b(lane0_ext), .is_signed(eff_sign),
    .sum_c(lane0_sum), .overflow_c(lane0_ovf)
  );

  pirdsp_sat_add #(.WIDTH(LANE_ACC_W), .SATURATE(SATURATE)) u_add_lane1 (
    .a(lane1_base), .b(lane1_ext), .is_signed(eff_sign),
    .sum_c(lane1_sum), .overflow_c(lane1_ovf)
  );

  // Next state, sticky overflow, beat count and mode-muxed result.
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      state_d = in_last ? IDLE : ACCUM;
    end
    ovf_d = (!start_c && ovf_q) || (eff_half ? (lane0_ovf || lane1_ovf) : full_ovf);
    if (start_c) begin
      count_d = CNT_W'(1);
    end else if (&count_q) begin
      count_d = count_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    acc0_d = full_sum;
    acc1_d = '0;
    if (eff_half) begin
      acc1_d = lane1_sum;
      if (eff_sign) begin
        acc0_d = ACC_W'($signed(lane0_sum));
      end else begin
        acc0_d = ACC_W'(lane0_sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half_q       <= 1'b0;
      sign_q       <= 1'b0;
      ovf_q        <= 1'b0;
      count_q      <= '0;
      full_q       <= '0;
      lane0_q      <= '0;
      lane1_q      <= '0;
      out_valid    <= 1'b0;
      out_acc0     <= '0;
      out_acc1     <= '0;
      out_half     <= 1'b0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      out_valid <= in_valid && in_last;
      if (in_valid) begin
        half_q  <= eff_half;
        sign_q  <= eff_sign;
        ovf_q   <= ovf_d;
        count_q <= count_d;
        full_q  <= full_sum;
        lane0_q <= lane0_sum;
        lane1_q <= lane1_sum;
        if (in_last) begin
          out_acc0     <= acc0_d;
          out_acc1     <= acc1_d;
          out_half     <= eff_half;
          out_count    <= count_d;
          out_overflow <= ovf_d;
        end
      end
    end
  end

endmodule

// File: doc/pirdsp_mac_accumulator_9x9.md
Name: pirdsp_mac_accumulator_9x9

Overview:
- Sits directly downstream of the 9x9 PIRDSP multiplier (signed/unsigned, HALF_1 split mode) and consumes its registered 18-bit product C.
- Accumulates a sequence of products into a full-width sum in full mode, or into two independent lane sums in half mode.
- Framing is driven by first/last flags. Optional saturation is provided, with a sticky overflow flag and a beat counter per accumulation.

Parameters:
- ACC_W, 32, full-mode accumulator width (≥18).
- LANE_ACC_W, 16, per-lane accumulator width in half mode (≥8, ≤ACC_W).
- CNT_W, 8, beat counter width.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_C is valid this cycle; aligned by the user to the multiplier's 1-cycle output register.
- in_C  in  18  multiplier product.
- in_sign  in  1  product is signed; set to A_sign|B_sign of the multiply.
- in_half  in  1  product was computed with HALF_1=1.
- in_first  in  1  beat starts a new accumulation.
- in_last  in  1  beat ends the accumulation.
- out_valid  out  1  one-cycle pulse; result registers updated.
- out_acc0  out  ACC_W  full sum (full mode) or lane0 sum extended to ACC_W (half mode).
- out_acc1  out  LANE_ACC_W  lane1 sum (half mode); 0 in full mode.
- out_half  out  1  mode of the reported result.
- out_count  out  CNT_W  beats in the reported accumulation; saturates at all-ones.
- out_overflow  out  1  any overflow occurred during the reported accumulation.

Behaviour:
- Reset: all outputs, working sums, counter, flags and state are 0; state is IDLE.
- States: IDLE (no open accumulation) and ACCUM. Only beats with in_valid=1 have any effect.
- Beat starts a new accumulation if in_first=1 or state is IDLE. It:
  - latches mode = in_half and sign = in_sign;
  - loads the working sums with the extended product (old sums discarded);
  - sets count to 1 and overflow to 0.
- Other beats in ACCUM: sum += extended product, using the latched mode/sign. in_half/in_sign are ignored on these beats. Count increments and saturates.
- Product extraction:
  - Full mode: the product is in_C[17:0], extended to ACC_W (sign-extended if sign, else zero-extended).
  - Half mode: lane0 = in_C[7:0], lane1 = in_C[17:10]. Each is extended independently to LANE_ACC_W. in_C[9:8] is ignored.
- Overflow detection:
  - Signed: operands have equal sign and the result sign differs.
  - Unsigned: carry out of the top bit.
- On overflow: with SATURATE=1 the sum clamps to max/min of its width; with SATURATE=0 it wraps. The sticky overflow flag is set either way and is shared by both lanes.
- Beat with in_last=1: the final sums (including this beat) are registered to the outputs. out_valid=1 on the next cycle; state returns to IDLE.
  - in_first=in_last on the same beat gives a single-product result.
  - A new in_first on the cycle after in_last is accepted with no bubble.
- In half mode, out_acc0 = lane0 sum extended from LANE_ACC_W to ACC_W per the latched sign.
- Output registers hold their values until the next out_valid. out_valid is 0 otherwise.
- in_first on a beat while in ACCUM, without a preceding in_last, abandons the open sum silently; no out_valid is produced.
- Reset mid-accumulation discards everything; out_valid stays 0.
- Latency: 1 cycle from the in_last beat to out_valid. Throughput: 1 beat/cycle.

Decomposition:
- Shared package pirdsp_pkg holds:
  - state enum {IDLE, ACCUM};
  - lane bit constants LANE0_LSB=0, LANE1_LSB=10, LANE_PROD_W=8, FULL_PROD_W=18.
- Sub-module pirdsp_sat_add (param WIDTH): a + b with signed/unsigned overflow detect and optional clamp. Instantiated three times: full, lane0, lane1. A mode mux selects the result.

Test Plan:
- Full signed: beats 18'h3FFD6 (-42, first) then 18'h00064 (100, last) → out_valid next cycle; out_acc0=58, out_count=2, out_half=0, out_overflow=0.
- Half signed: two beats of in_C with [7:0]=8'hF4 and [17:10]=8'h0F, second beat last → out_acc0=32'hFFFFFFE8 (-24), out_acc1=16'd30, out_half=1.
- Saturation (LANE_ACC_W=10, half, unsigned): 5 beats of lane0=8'hFF → out_acc0=10'h3FF zero-extended, out_overflow=1. With SATURATE=0, out_acc0=1275 mod 1024=251.
- Framing: first+last on a single beat 18'h00005, then a new first on the next cycle → two consecutive out_valid pulses, values 5 and the new sum, counts 1 and n.
- Reset mid-op: 3 beats with no last, then reset, then first+last 18'h00007 → out_valid only for the final beat, out_acc0=7, out_count=1.
- Unsigned full: 18'h3FFFF ×2 → out_acc0=32'h0007FFFE, no overflow.
